// File: rtl/nasti_read_burst_splitter_pkg.sv
// Shared NASTI definitions for the read burst splitter: FSM states, AR burst
// and R response encodings, and the 4 KB page size.
package nasti_read_burst_splitter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Bytes in one page; a burst must never cross this boundary.
    localparam logic [12:0] BYTES_4K = 13'h1000;

endpackage

// File: rtl/nasti_read_burst_splitter_if.sv
// NASTI read-channel bundle (AR + R). The master modport issues requests and
// consumes data; the slave modport is its mirror image.
interface nasti_read_burst_splitter_if #(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_lock;
    logic [3:0]            ar_cache;
    logic [2:0]            ar_prot;
    logic [3:0]            ar_qos;
    logic [3:0]            ar_region;
    logic [USER_WIDTH-1:0] ar_user;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/nasti_read_burst_splitter_chunker.sv
// nasti_burst_chunker: combinational sub-burst size and follow-on address for
// an INCR burst. Shared with the write-side splitter.
// Optional macro NASTI_SPLIT_4K_EN: also stop each chunk at the next 4 KB page.
module nasti_burst_chunker
    import nasti_read_burst_splitter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [8:0]            beats_rem_i,
    input  logic [2:0]            size_i,
    output logic [8:0]            chunk_o,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);
    localparam logic [8:0] MAX_CHUNK = 9'(MAX_BEATS);

    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic [8:0]            chunk;
`ifdef NASTI_SPLIT_4K_EN
    logic [12:0]           beats_4k;
`endif

    // Take the smallest of remaining beats, MAX_BEATS and (optionally) beats to the page edge.
    always_comb begin
        // NOTE: every combinational output gets a value before any condition, so no latch is inferred.
        addr_aligned = addr_i & ~((ADDR_WIDTH'(1) << size_i) - ADDR_WIDTH'(1));
        chunk        = (beats_rem_i < MAX_CHUNK) ? beats_rem_i : MAX_CHUNK;
`ifdef NASTI_SPLIT_4K_EN
        beats_4k = (BYTES_4K - {1'b0, addr_aligned[11:0]}) >> size_i;
        if ({4'b0, chunk} > beats_4k) begin
            chunk = beats_4k[8:0];
        end
`endif
        chunk_o     = chunk;
        next_addr_o = addr_aligned + (ADDR_WIDTH'(chunk) << size_i);
    end

endmodule

// File: rtl/nasti_read_burst_splitter.sv
// nasti_read_burst_splitter: splits one master INCR read burst into slave
// sub-bursts of at most MAX_BEATS beats and re-merges the R stream so only the
// final beat carries r_last. One outstanding transaction at a time.
// Optional macro NASTI_SPLIT_4K_EN (in nasti_burst_chunker): never cross 4 KB.
module nasti_read_burst_splitter
    import nasti_read_burst_splitter_pkg::*;
#(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BEATS  = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    nasti_read_burst_splitter_if.slave         master_if,
    nasti_read_burst_splitter_if.master        slave_if
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            beats_rem_q, beats_rem_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [7:0]            cur_len_q, cur_len_d;

    // Latched request fields, replayed on every sub-burst.
    logic [ID_WIDTH-1:0]   id_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  lock_q;
    logic [3:0]            cache_q;
    logic [2:0]            prot_q;
    logic [3:0]            qos_q;
    logic [3:0]            region_q;
    logic [USER_WIDTH-1:0] user_q;

    logic [8:0]            chunk;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  master_ar_hs, slave_ar_hs, slave_r_hs;
    logic                  unused_r_id;

    nasti_burst_chunker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_chunker (
        .addr_i      (addr_q),
        .beats_rem_i (beats_rem_q),
        .size_i      (size_q),
        .chunk_o     (chunk),
        .next_addr_o (next_addr)
    );

    assign master_ar_hs = master_if.ar_valid && master_if.ar_ready;
    assign slave_ar_hs  = slave_if.ar_valid && slave_if.ar_ready;
    assign slave_r_hs   = slave_if.r_valid && slave_if.r_ready;
    // The downstream ID is not trusted; the latched request ID is returned instead.
    assign unused_r_id  = ^slave_if.r_id;

    // Request handshake and sub-burst AR fields.
    assign master_if.ar_ready  = (state_q == S_IDLE);
    assign slave_if.ar_valid  = (state_q == S_AR);
    assign slave_if.ar_id     = id_q;
    assign slave_if.ar_addr   = addr_q;
    assign slave_if.ar_len    = 8'(chunk - 9'd1);
    assign slave_if.ar_size   = size_q;
    assign slave_if.ar_burst  = burst_q;
    assign slave_if.ar_lock   = lock_q;
    assign slave_if.ar_cache  = cache_q;
    assign slave_if.ar_prot   = prot_q;
    assign slave_if.ar_qos    = qos_q;
    assign slave_if.ar_region = region_q;
    assign slave_if.ar_user   = user_q;

    // Zero-latency R pass-through, gated to the data phase.
    assign master_if.r_valid = slave_if.r_valid && (state_q == S_R);
    assign slave_if.r_ready  = master_if.r_ready && (state_q == S_R);
    assign master_if.r_id    = id_q;
    assign master_if.r_data  = slave_if.r_data;
    assign master_if.r_resp  = slave_if.r_resp;
    assign master_if.r_user  = slave_if.r_user;
    assign master_if.r_last  = slave_if.r_last && (beats_rem_q == 9'd0);

    // Next-state logic: accept request, issue sub-burst AR, stream its beats, repeat.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beats_rem_d = beats_rem_q;
        beat_cnt_d  = beat_cnt_q;
        cur_len_d   = cur_len_q;
        unique case (state_q)
            S_IDLE: begin
                if (master_ar_hs) begin
                    state_d     = S_AR;
                    addr_d      = master_if.ar_addr;
                    beats_rem_d = {1'b0, master_if.ar_len} + 9'd1;
                end
            end
            S_AR: begin
                if (slave_ar_hs) begin
                    state_d     = S_R;
                    addr_d      = next_addr;
                    beats_rem_d = beats_rem_q - chunk;
                    beat_cnt_d  = 8'd0;
                    cur_len_d   = 8'(chunk - 9'd1);
                end
            end
            S_R: begin
                if (slave_r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (slave_if.r_last) begin
                        state_d = (beats_rem_q == 9'd0) ? S_IDLE : S_AR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and burst-progress registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            beats_rem_q <= '0;
            beat_cnt_q  <= '0;
            cur_len_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            beats_rem_q <= beats_rem_d;
            beat_cnt_q  <= beat_cnt_d;
            cur_len_q   <= cur_len_d;
        end
    end

    // Capture the request fields that every sub-burst repeats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q     <= '0;
            size_q   <= '0;
            burst_q  <= BURST_INCR;
            lock_q   <= 1'b0;
            cache_q  <= '0;
            prot_q   <= '0;
            qos_q    <= '0;
            region_q <= '0;
            user_q   <= '0;
        end else if (master_ar_hs) begin
            id_q     <= master_if.ar_id;
            size_q   <= master_if.ar_size;
            burst_q  <= master_if.ar_burst;
            lock_q   <= master_if.ar_lock;
            cache_q  <= master_if.ar_cache;
            prot_q   <= master_if.ar_prot;
            qos_q    <= master_if.ar_qos;
            region_q <= master_if.ar_region;
            user_q   <= master_if.ar_user;
        end
    end

    // Protocol sanity checks on requests and sub-burst beat framing.
    always @(posedge clk) begin
        if (rstn && master_ar_hs) begin
            assert (master_if.ar_burst == BURST_INCR && master_if.ar_size <= MAX_SIZE)
            else $fatal(1, "unsupported read request: burst %0d size %0d",
                        master_if.ar_burst, master_if.ar_size);
        end
        if (rstn && slave_r_hs) begin
            assert (slave_if.r_last == (beat_cnt_q == cur_len_q))
            else $fatal(1, "slave r_last misplaced at beat %0d of len %0d",
                        beat_cnt_q, cur_len_q);
        end
    end

endmodule

// File: tb/tb_nasti_read_burst_splitter.sv
// Scoreboard bench for nasti_read_burst_splitter: directed requests push the
// expected slave ARs and merged R beats; a monitor pops and compares them on
// every handshake. Expectations for NASTI_SPLIT_4K_EN follow the macro.
module tb_nasti_read_burst_splitter;
    import nasti_read_burst_splitter_pkg::*;

    localparam int ID_WIDTH   = 2;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int USER_WIDTH = 1;
    localparam int MAX_BEATS  = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    nasti_read_burst_splitter_if #(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH) m_if ();
    nasti_read_burst_splitter_if #(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH) s_if ();

    nasti_read_burst_splitter #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .master_if (m_if),
        .slave_if  (s_if)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [1:0] id; logic user; } r_exp_t;

    ar_exp_t exp_ar[$];
    r_exp_t  exp_r[$];
    int checks     = 0;
    int errors     = 0;
    int beats_seen = 0;
    int ar_delay   = 0;
    bit rdy_toggle = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-address beat contents returned by the slave model.
    function automatic logic [63:0] beat_data(input logic [31:0] a);
        return {~a, a};
    endfunction
    function automatic logic [1:0] beat_resp(input logic [31:0] a);
        return (a == 32'h88) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int k);
        return (k == 0) ? start : ((start & ~32'h7) + 32'(k) * 32'd8);
    endfunction

    // Slave memory model: accepts one AR (after ar_delay cycles), returns its beats.
    initial begin : slave_model
        bit          busy = 1'b0;
        logic [31:0] b_addr = '0;
        logic [7:0]  b_len = '0;
        logic [7:0]  b_idx = '0;
        logic [1:0]  b_id = '0;
        logic [31:0] a;
        int          wait_cnt = 0;
        s_if.ar_ready = 1'b0;
        s_if.r_valid  = 1'b0;
        s_if.r_id     = '0;
        s_if.r_data   = '0;
        s_if.r_resp   = '0;
        s_if.r_last   = 1'b0;
        s_if.r_user   = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                busy = 1'b0; wait_cnt = 0;
                s_if.ar_ready = 1'b0; s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
                continue;
            end
            if (!busy) begin
                s_if.r_valid  = 1'b0;
                s_if.r_last   = 1'b0;
                s_if.ar_ready = s_if.ar_valid && (wait_cnt >= ar_delay);
                if (s_if.ar_valid) wait_cnt++;
            end else begin
                a = beat_addr(b_addr, int'(b_idx));
                s_if.ar_ready = 1'b0;
                s_if.r_valid  = 1'b1;
                s_if.r_id     = ~b_id;
                s_if.r_data   = beat_data(a);
                s_if.r_resp   = beat_resp(a);
                s_if.r_user   = a[3];
                s_if.r_last   = (b_idx == b_len);
            end
            #1;
            if (rstn) begin
                if (!busy && s_if.ar_valid && s_if.ar_ready) begin
                    busy = 1'b1; b_addr = s_if.ar_addr; b_len = s_if.ar_len;
                    b_idx = 8'd0; b_id = s_if.ar_id; wait_cnt = 0;
                end else if (busy && s_if.r_ready) begin
                    if (b_idx == b_len) busy = 1'b0;
                    b_idx++;
                end
            end
        end
    end

    // Master R ready: always on, or toggling 1010... when requested.
    initial begin
        m_if.r_ready = 1'b0;
        forever begin
            @(negedge clk);
            m_if.r_ready = rdy_toggle ? ~m_if.r_ready : 1'b1;
        end
    end

    // Monitor: every handshake pops its expected entry and compares.
    initial begin : monitor
        ar_exp_t ea;
        r_exp_t  er;
        forever begin
            @(negedge clk);
            #2;
            if (rstn) begin
                if (s_if.ar_valid && s_if.ar_ready) begin
                    if (exp_ar.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL slave_ar_extra: got addr %h len %0d expected none", s_if.ar_addr, s_if.ar_len);
                    end else begin
                        ea = exp_ar.pop_front();
                        check("slave_ar_addr", 64'(s_if.ar_addr), 64'(ea.addr));
                        check("slave_ar_len", 64'(s_if.ar_len), 64'(ea.len));
                    end
                end
                if (m_if.r_valid && m_if.r_ready) begin
                    beats_seen++;
                    if (exp_r.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL master_r_extra: got data %h expected none", m_if.r_data);
                    end else begin
                        er = exp_r.pop_front();
                        check("r_data", m_if.r_data, er.data);
                        check("r_resp", 64'(m_if.r_resp), 64'(er.resp));
                        check("r_last", 64'(m_if.r_last), 64'(er.last));
                        check("r_id", 64'(m_if.r_id), 64'(er.id));
                        check("r_user", 64'(m_if.r_user), 64'(er.user));
                    end
                end
            end
        end
    end

    task automatic push_ar(input logic [31:0] addr, input logic [7:0] len);
        exp_ar.push_back('{addr: addr, len: len});
    endtask

    // Issue one master read; returns on the negedge after the AR handshake.
    task automatic issue(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len);
        logic [31:0] a;
        int c;
        for (int k = 0; k <= int'(len); k++) begin
            a = beat_addr(addr, k);
            exp_r.push_back('{data: beat_data(a), resp: beat_resp(a), last: (k == int'(len)), id: id, user: a[3]});
        end
        @(negedge clk);
        m_if.ar_valid = 1'b1; m_if.ar_id = id; m_if.ar_addr = addr; m_if.ar_len = len;
        m_if.ar_size = 3'd3; m_if.ar_burst = BURST_INCR;
        c = 0;
        while (1) begin
            #1;
            if (m_if.ar_ready) break;
            if (c >= 200) begin
                checks++; errors++;
                $display("FAIL master_ar_timeout: got ready 0 expected 1");
                break;
            end
            c++;
            @(negedge clk);
        end
        @(negedge clk);
        m_if.ar_valid = 1'b0;
    endtask

    // Wait for all expected traffic, then confirm the splitter is idle again.
    task automatic wait_done(input string name);
        int c = 0;
        while ((exp_r.size() != 0 || exp_ar.size() != 0) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 3000) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_r.size());
            exp_r.delete(); exp_ar.delete();
        end
        @(negedge clk);
        #1;
        check({name, "_idle_ar_ready"}, 64'(m_if.ar_ready), 64'd1);
        check({name, "_idle_r_valid"}, 64'(m_if.r_valid), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int c;
        int target;
        m_if.ar_valid = 1'b0; m_if.ar_id = '0; m_if.ar_addr = '0; m_if.ar_len = '0;
        m_if.ar_size = 3'd3; m_if.ar_burst = BURST_INCR; m_if.ar_lock = 1'b0;
        m_if.ar_cache = '0; m_if.ar_prot = '0; m_if.ar_qos = '0; m_if.ar_region = '0; m_if.ar_user = '0;

        #2 rstn = 1'b0;
        #1;
        check("reset_master_ar_ready", 64'(m_if.ar_ready), 64'd1);
        check("reset_slave_ar_valid", 64'(s_if.ar_valid), 64'd0);
        check("reset_master_r_valid", 64'(m_if.r_valid), 64'd0);
        check("reset_slave_r_ready", 64'(s_if.r_ready), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // 1: short burst, single sub-burst; slave AR follows one cycle after the request.
        push_ar(32'h100, 8'd3);
        issue(2'd1, 32'h100, 8'd3);
        #1;
        check("ar_latency_slave_ar_valid", 64'(s_if.ar_valid), 64'd1);
        wait_done("t1");

        // 2: 40 beats split 16/16/8, including an SLVERR beat at 0x88.
        push_ar(32'h0, 8'd15); push_ar(32'h80, 8'd15); push_ar(32'h100, 8'd7);
        issue(2'd2, 32'h0, 8'd39);
        wait_done("t2");

        // 3: burst approaching a 4 KB boundary.
`ifdef NASTI_SPLIT_4K_EN
        push_ar(32'hFE0, 8'd3); push_ar(32'h1000, 8'd3);
`else
        push_ar(32'hFE0, 8'd7);
`endif
        issue(2'd3, 32'hFE0, 8'd7);
        wait_done("t3");

        // 4: unaligned start one word below the boundary.
`ifdef NASTI_SPLIT_4K_EN
        push_ar(32'hFFC, 8'd0); push_ar(32'h1000, 8'd0);
`else
        push_ar(32'hFFC, 8'd1);
`endif
        issue(2'd0, 32'hFFC, 8'd1);
        wait_done("t4");

        // 5: backpressure on R and slow slave AR acceptance.
        rdy_toggle = 1'b1;
        ar_delay   = 3;
        push_ar(32'h2000, 8'd15); push_ar(32'h2080, 8'd15); push_ar(32'h2100, 8'd7);
        issue(2'd3, 32'h2000, 8'd39);
        wait_done("t5");
        rdy_toggle = 1'b0;
        ar_delay   = 0;

        // 6: reset during the second sub-burst's data phase.
        push_ar(32'h0, 8'd15); push_ar(32'h80, 8'd15); push_ar(32'h100, 8'd7);
        target = beats_seen + 18;
        issue(2'd2, 32'h0, 8'd39);
        c = 0;
        while (beats_seen < target && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (c >= 500) begin
            checks++; errors++;
            $display("FAIL t6_reach_second_burst: got %0d beats expected %0d", beats_seen, target);
        end
        rstn = 1'b0;
        #1;
        check("t6_reset_master_ar_ready", 64'(m_if.ar_ready), 64'd1);
        check("t6_reset_master_r_valid", 64'(m_if.r_valid), 64'd0);
        check("t6_reset_slave_ar_valid", 64'(s_if.ar_valid), 64'd0);
        exp_r.delete();
        exp_ar.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        push_ar(32'h100, 8'd3);
        issue(2'd1, 32'h100, 8'd3);
        wait_done("t6_after_reset");

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
